// File: rtl/pe_bfly_gen_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg -- shared definitions for the generalised butterfly PE.
//
// Contents:
//   mode_e        token operating mode (CT, GS halved, MUL, GS unhalved)
//   Q0_DEF/Q1_DEF default Kyber / Dilithium moduli
//   barrett_k/mu  Barrett constants, k = ceil(log2 q), mu = floor(2^(2k)/q)
//   mod_add/sub/half  canonical modular helpers with q as an argument
//
// The helpers work on a 32-bit word so one package serves any DATA_W up to
// 31 bits; callers zero-extend their operands and truncate the result.
// ---------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [1:0] {
        MODE_CT  = 2'b00,
        MODE_GS  = 2'b01,
        MODE_MUL = 2'b10,
        MODE_GSU = 2'b11
    } mode_e;

    localparam int Q0_DEF = 3329;
    localparam int Q1_DEF = 8380417;

    typedef logic [31:0] word_t;

    // Both GS variants share bit 0; they run add/sub ahead of the multiplier.
    function automatic logic mode_is_gs(input mode_e m);
        return m[0];
    endfunction

    function automatic int barrett_k(input longint unsigned q);
        return $clog2(q);
    endfunction

    function automatic longint unsigned barrett_mu(input longint unsigned q);
        return (64'd1 << (2 * barrett_k(q))) / q;
    endfunction

    localparam longint unsigned MU0_DEF = barrett_mu(Q0_DEF);
    localparam longint unsigned MU1_DEF = barrett_mu(Q1_DEF);

    function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[31:0];
    endfunction

    function automatic word_t mod_sub(input word_t a, input word_t b, input word_t q);
        logic [32:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, a} + {1'b0, q} - {1'b0, b};
        return d[31:0];
    endfunction

    // Division by two in Z_q: odd values borrow one q to become even first.
    function automatic word_t mod_half(input word_t x, input word_t q);
        logic [32:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
        return t[32:1];
    endfunction

endpackage

// File: rtl/pe_bfly_gen_if.sv
// ---------------------------------------------------------------------------
// pe_bfly_gen_if -- token bus of the butterfly PE.
//
// master : token producer/consumer (drives en, in_*, samples out_*, busy)
// slave  : the PE itself
//
// Signals: en (global advance), in_valid, mode, q_sel, in_a, in_b, in_w,
//          in_tag, out_valid, out_a, out_b, out_tag, busy.
// ---------------------------------------------------------------------------
interface pe_bfly_gen_if
    import pe_pkg::*;
#(
    parameter int DATA_W = 23,
    parameter int TAG_W  = 8
) ();

    logic              en;
    logic              in_valid;
    mode_e             mode;
    logic              q_sel;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] in_w;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport master (
        output en, in_valid, mode, q_sel, in_a, in_b, in_w, in_tag,
        input  out_valid, out_a, out_b, out_tag, busy
    );

    modport slave (
        input  en, in_valid, mode, q_sel, in_a, in_b, in_w, in_tag,
        output out_valid, out_a, out_b, out_tag, busy
    );

endinterface

// File: rtl/pe_bfly_gen_mul.sv
// ---------------------------------------------------------------------------
// mod_mul_pipe -- pipelined modular multiplier, p = x*y mod q.
//
// Ports:
//   clk      clock
//   en       global advance; 0 freezes every stage
//   x_i,y_i  canonical operands [0,q)
//   q_sel_i  0 -> Q0, 1 -> Q1 (travels with the operands)
//   p_o      product, valid exactly MUL_LAT enabled cycles after sampling
//
// The raw product is registered first; Barrett reduction with a single
// conditional subtract sits in the last stage. With MUL_LAT=1 both collapse
// into one stage.
// ---------------------------------------------------------------------------
module mod_mul_pipe
    import pe_pkg::*;
#(
    parameter int DATA_W  = 23,
    parameter int Q0      = Q0_DEF,
    parameter int Q1      = Q1_DEF,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic              q_sel_i,
    output logic [DATA_W-1:0] p_o
);

    localparam int PW = 2 * DATA_W;      // product width
    localparam int MW = DATA_W + 2;      // mu < 2^(k+1)
    localparam int RW = PW + MW;         // product * mu

    localparam int             K0  = barrett_k(longint'(Q0));
    localparam int             K1  = barrett_k(longint'(Q1));
    localparam logic [MW-1:0]  MU0 = MW'(barrett_mu(longint'(Q0)));
    localparam logic [MW-1:0]  MU1 = MW'(barrett_mu(longint'(Q1)));
    localparam logic [PW-1:0]  QW0 = PW'(Q0);
    localparam logic [PW-1:0]  QW1 = PW'(Q1);

    // p < q^2 < 2^(2k), so qhat = floor(p*mu / 2^(2k)) is at most one short
    // of floor(p/q) and the remainder is below 2q.
    function automatic logic [DATA_W-1:0] barrett_reduce(input logic [PW-1:0] p,
                                                         input logic sel);
        logic [RW-1:0] pm;
        logic [PW-1:0] qhat;
        logic [PW-1:0] q;
        logic [PW-1:0] r;
        q    = sel ? QW1 : QW0;
        pm   = RW'(p) * RW'(sel ? MU1 : MU0);
        qhat = PW'(pm >> (sel ? 2 * K1 : 2 * K0));
        r    = p - qhat * q;
        if (r >= q) r = r - q;
        return DATA_W'(r);
    endfunction

    logic [PW-1:0]     prod_in;
    logic [DATA_W-1:0] res_q;

    assign prod_in = PW'(x_i) * PW'(y_i);
    assign p_o     = res_q;

    // NOTE: pure datapath registers carry no reset; a token's validity is
    // tracked separately, so their contents before the first token never matter.
    generate
        if (MUL_LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (en) res_q <= barrett_reduce(prod_in, q_sel_i);
            end
        end else begin : g_multi
            logic [PW-1:0] prod_q [MUL_LAT-1];
            logic          sel_q  [MUL_LAT-1];

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the pre-edge value of its neighbour.
            always_ff @(posedge clk) begin
                if (en) begin
                    prod_q[0] <= prod_in;
                    sel_q[0]  <= q_sel_i;
                    for (int i = 1; i < MUL_LAT - 1; i++) begin
                        prod_q[i] <= prod_q[i-1];
                        sel_q[i]  <= sel_q[i-1];
                    end
                    res_q <= barrett_reduce(prod_q[MUL_LAT-2], sel_q[MUL_LAT-2]);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pe_bfly_gen.sv
// ---------------------------------------------------------------------------
// pe_bfly_gen -- generalised butterfly PE for the shared NTT/INTT array.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (wins over en)
//   bus   pe_bfly_gen_if.slave: en, in_valid, mode, q_sel, in_a/b/w, in_tag,
//         out_valid, out_a/b, out_tag, busy
//
// Pipeline (LAT = MUL_LAT + 2, identical for every mode):
//   S1   GS modes: s = a+b, d = a-b; other modes: a, b pass through
//   MUL  (b or d) * w mod q, with the S1 'a' lane and sideband delayed alongside
//   S3   CT: a+t / a-t; GS: half(s) / half(m); MUL: m / a; GSU: s / m
// ---------------------------------------------------------------------------
module pe_bfly_gen
    import pe_pkg::*;
#(
    parameter int DATA_W  = 23,
    parameter int Q0      = Q0_DEF,
    parameter int Q1      = Q1_DEF,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    pe_bfly_gen_if.slave   bus
);

    // Sideband plus the operand lane that bypasses the multiplier.
    typedef struct packed {
        mode_e             mode;
        logic              q_sel;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] a;
    } side_t;

    function automatic logic [DATA_W-1:0] q_of(input logic sel);
        return sel ? DATA_W'(Q1) : DATA_W'(Q0);
    endfunction

    function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] q);
        return DATA_W'(mod_add(word_t'(a), word_t'(b), word_t'(q)));
    endfunction

    function automatic logic [DATA_W-1:0] f_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] q);
        return DATA_W'(mod_sub(word_t'(a), word_t'(b), word_t'(q)));
    endfunction

    function automatic logic [DATA_W-1:0] f_half(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] q);
        return DATA_W'(mod_half(word_t'(x), word_t'(q)));
    endfunction

    // ---------------- stage 1: pre add/sub ----------------
    logic [DATA_W-1:0] s1_a_d, s1_b_d, q_pre;
    logic              s1_valid_q;
    side_t             s1_side_q;
    logic [DATA_W-1:0] s1_b_q, s1_w_q;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        q_pre  = q_of(bus.q_sel);
        s1_a_d = bus.in_a;
        s1_b_d = bus.in_b;
        if (mode_is_gs(bus.mode)) begin
            s1_a_d = f_add(bus.in_a, bus.in_b, q_pre);
            s1_b_d = f_sub(bus.in_a, bus.in_b, q_pre);
        end
    end

    // ---------------- multiplier and bypass lane ----------------
    logic [DATA_W-1:0] mul_p;
    logic              mid_valid_q [MUL_LAT];
    side_t             mid_q       [MUL_LAT];

    mod_mul_pipe #(
        .DATA_W  (DATA_W),
        .Q0      (Q0),
        .Q1      (Q1),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .en      (bus.en),
        .x_i     (s1_b_q),
        .y_i     (s1_w_q),
        .q_sel_i (s1_side_q.q_sel),
        .p_o     (mul_p)
    );

    // ---------------- stage 3: post add/sub/half ----------------
    side_t             last;
    logic [DATA_W-1:0] q_post, out_a_d, out_b_d;
    logic              out_valid_q, busy_d;
    logic [DATA_W-1:0] out_a_q, out_b_q;
    logic [TAG_W-1:0]  out_tag_q;

    assign last = mid_q[MUL_LAT-1];

    always_comb begin
        q_post  = q_of(last.q_sel);
        out_a_d = last.a;
        out_b_d = mul_p;
        case (last.mode)
            MODE_CT: begin
                out_a_d = f_add(last.a, mul_p, q_post);
                out_b_d = f_sub(last.a, mul_p, q_post);
            end
            MODE_GS: begin
                out_a_d = f_half(last.a, q_post);
                out_b_d = f_half(mul_p, q_post);
            end
            MODE_MUL: begin
                out_a_d = mul_p;
                out_b_d = last.a;
            end
            default: begin
                out_a_d = last.a;
                out_b_d = mul_p;
            end
        endcase
    end

    // Valid bits and outputs: reset, then advance only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) mid_valid_q[i] <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_tag_q   <= '0;
        end else if (bus.en) begin
            s1_valid_q     <= bus.in_valid;
            mid_valid_q[0] <= s1_valid_q;
            for (int i = 1; i < MUL_LAT; i++) mid_valid_q[i] <= mid_valid_q[i-1];
            out_valid_q <= mid_valid_q[MUL_LAT-1];
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_tag_q   <= last.tag;
        end
    end

    // Internal datapath: free-running under en, contents of empty slots ignored.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            s1_side_q <= '{mode: bus.mode, q_sel: bus.q_sel, tag: bus.in_tag, a: s1_a_d};
            s1_b_q    <= s1_b_d;
            s1_w_q    <= bus.in_w;
            mid_q[0]  <= s1_side_q;
            for (int i = 1; i < MUL_LAT; i++) mid_q[i] <= mid_q[i-1];
        end
    end

    always_comb begin
        busy_d = s1_valid_q | out_valid_q;
        for (int i = 0; i < MUL_LAT; i++) busy_d = busy_d | mid_valid_q[i];
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.busy      = busy_d;

endmodule

// File: tb/tb_pe_bfly_gen.sv
// ---------------------------------------------------------------------------
// tb_pe_bfly_gen -- directed bench for pe_bfly_gen (MUL_LAT=3, LAT=5).
// Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pe_bfly_gen;
    import pe_pkg::*;

    localparam int DATA_W  = 23;
    localparam int TAG_W   = 8;
    localparam int MUL_LAT = 3;
    localparam int LAT     = MUL_LAT + 2;
    localparam int unsigned QK = 3329;
    localparam int unsigned QD = 8380417;
    localparam int NS = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        mode_e       m;
        logic        qs;
        int unsigned a, b, w, ea, eb;
    } vec_t;

    vec_t stream [NS];

    pe_bfly_gen_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    pe_bfly_gen #(
        .DATA_W  (DATA_W),
        .Q0      (QK),
        .Q1      (QD),
        .MUL_LAT (MUL_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] tag,
                             input int unsigned ea, input int unsigned eb);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_tag"},   32'(bus.out_tag),   32'(tag));
        check({name, "_a"},     32'(bus.out_a),     ea);
        check({name, "_b"},     32'(bus.out_b),     eb);
    endtask

    task automatic drive(input mode_e m, input logic qs, input int unsigned a,
                         input int unsigned b, input int unsigned w, input logic [7:0] tag);
        int unsigned q;
        q = qs ? QD : QK;
        assert (a < q && b < q && w < q)
        else $fatal(1, "FAIL stimulus: non-canonical operand");
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.q_sel    = qs;
        bus.in_a     = DATA_W'(a);
        bus.in_b     = DATA_W'(b);
        bus.in_w     = DATA_W'(w);
        bus.in_tag   = tag;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // One isolated token: result must be absent after LAT-1 cycles, present after LAT.
    task automatic single(input string name, input mode_e m, input logic qs,
                          input int unsigned a, input int unsigned b, input int unsigned w,
                          input logic [7:0] tag, input int unsigned ea, input int unsigned eb);
        drive(m, qs, a, b, w, tag);
        tick();
        idle();
        repeat (LAT - 2) tick();
        check({name, "_early"}, 32'(bus.out_valid), 32'd0);
        tick();
        check_out(name, tag, ea, eb);
    endtask

    initial begin
        stream[0] = '{MODE_CT,  1'b0, 1,    2,    17,   35,      3296};
        stream[1] = '{MODE_GS,  1'b1, 5,    2,    17,   4190212, 4190234};
        stream[2] = '{MODE_MUL, 1'b0, 9,    100,  200,  26,      9};
        stream[3] = '{MODE_GSU, 1'b1, 3,    10,   1000, 13,      8373417};
        stream[4] = '{MODE_CT,  1'b0, 100,  3,    5,    115,     85};
        stream[5] = '{MODE_GS,  1'b1, 3000, 1000, 3,    2000,    3000};

        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode     = MODE_CT;
        bus.q_sel    = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_w     = '0;
        bus.in_tag   = '0;

        // Reset state.
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_a",     32'(bus.out_a),     32'd0);
        check("rst_b",     32'(bus.out_b),     32'd0);
        check("rst_tag",   32'(bus.out_tag),   32'd0);
        rst = 1'b0;
        tick();

        // Isolated tokens with exact latency.
        single("ct_k",   MODE_CT,  1'b0, 1, 2, 17,      8'h11, 35,      3296);
        single("ct_d",   MODE_CT,  1'b1, 0, 1, QD - 1,  8'h22, QD - 1,  1);
        single("mul_d",  MODE_MUL, 1'b1, 9, 2, QD - 1,  8'h33, QD - 2,  9);
        tick();
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        check("idle_busy",  32'(bus.busy),      32'd0);

        // Back-to-back stream with mixed modes and moduli.
        for (int i = 0; i < NS + LAT; i++) begin
            int j;
            if (i < NS) drive(stream[i].m, stream[i].qs, stream[i].a, stream[i].b,
                              stream[i].w, 8'(8'h40 + i));
            else        idle();
            tick();
            j = i + 1 - LAT;
            if (j == -1 || j == NS)
                check($sformatf("strm_gap%0d", j), 32'(bus.out_valid), 32'd0);
            else if (j >= 0 && j < NS)
                check_out($sformatf("strm%0d", j), 8'(8'h40 + j), stream[j].ea, stream[j].eb);
        end

        // Stall with three tokens in flight.
        drive(MODE_CT,  1'b0, 1, 2, 17, 8'hA0); tick();
        drive(MODE_GS,  1'b0, 5, 2, 17, 8'hA1); tick();
        drive(MODE_GSU, 1'b0, 5, 2, 17, 8'hA2); tick();
        idle();
        tick();
        tick();
        check_out("stl0", 8'hA0, 35, 3296);
        bus.en = 1'b0;
        drive(MODE_CT, 1'b0, 7, 7, 7, 8'hEE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("frz%0d", i), 8'hA0, 35, 3296);
            check($sformatf("frz%0d_busy", i), 32'(bus.busy), 32'd1);
        end
        bus.en = 1'b1;
        idle();
        tick();
        check_out("stl1", 8'hA1, 1668, 1690);
        tick();
        check_out("stl2", 8'hA2, 7, 51);
        tick();
        check("stl_end_valid", 32'(bus.out_valid), 32'd0);
        check("stl_end_busy",  32'(bus.busy),      32'd0);

        // Reset with the pipeline full, en low to show rst wins.
        for (int i = 0; i < NS; i++) begin
            drive(stream[i].m, stream[i].qs, stream[i].a, stream[i].b, stream[i].w, 8'(8'h60 + i));
            tick();
        end
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst    = 1'b1;
        bus.en = 1'b0;
        tick();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        check("mid_rst_a",     32'(bus.out_a),     32'd0);
        check("mid_rst_b",     32'(bus.out_b),     32'd0);
        check("mid_rst_tag",   32'(bus.out_tag),   32'd0);
        rst    = 1'b0;
        bus.en = 1'b1;
        idle();
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            check($sformatf("no_stale%0d", i), 32'(bus.out_valid), 32'd0);
        end
        single("post_rst", MODE_GSU, 1'b0, 5, 2, 17, 8'h5A, 7, 51);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
